// File: rtl/prob_circ_pkg.sv
// Shared types and helpers for the sum-node accumulator.
// The default lane width comes from the `DW macro (16 when not defined
// elsewhere); node_sum_accum's DW parameter is expected to match it.
`ifndef DW
`define DW 16
`endif

package prob_circ_pkg;

  localparam int DW_DEF = `DW;
  // Mantissa bits per lane and accumulator width for the default lane width.
  localparam int MW = DW_DEF - 8;
  localparam int AW = DW_DEF + 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_DRAIN = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } node_sum_state_t;

  // Exponent field of one lane.
  function automatic logic [7:0] lane_exp(input logic [DW_DEF-1:0] lane);
    return lane[DW_DEF-1 -: 8];
  endfunction

  // Mantissa field of one lane.
  function automatic logic [MW-1:0] lane_man(input logic [DW_DEF-1:0] lane);
    return lane[MW-1:0];
  endfunction

endpackage

// File: rtl/node_sum_accum_lead_one_det.sv
// Priority encoder: position of the most significant set bit plus a zero flag.
module lead_one_det #(
  parameter int W  = 22,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  // Ascending scan, so the highest set bit is the last one written.
  always_comb begin
    o_pos  = '0;
    o_zero = (i_vec == '0);
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_pos = PW'(i);
    end
  end

endmodule

// File: rtl/node_sum_accum.sv
// Sum-node accumulator: aligns 4-lane lines of custom floats to the node's
// maximum exponent, accumulates them in fixed point and renormalizes the total.
// Optional feature macro: NODE_SUM_ROUND_EN (round half-up instead of truncate).
// Handshakes: a line moves when in_vld && in_ready on a rising edge; a sum
// moves when sum_vld && sum_ready; sum_out is stable while sum_vld waits.
module node_sum_accum
  import prob_circ_pkg::*;
#(
  parameter int DW    = `DW,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_ready,
  input  logic [7:0]            max_exponent,
  input  logic                  max_exponent_vld,
  input  logic [10:0]           num_of_line_per_node_minusone,
  output logic [DW-1:0]         sum_out,
  output logic                  sum_vld,
  input  logic                  sum_ready,
  output logic                  exp_err,
  output node_sum_state_t       dbg_state
);

  localparam int MW_L = DW - 8;
  localparam int AW_L = DW + 6;
  localparam int SW   = MW_L + 3;
  localparam int PW   = $clog2(AW_L);

  node_sum_state_t  r_state;
  logic [7:0]       r_emax;
  logic [10:0]      r_last;
  logic [10:0]      r_cnt;
  logic             r_in_ready;
  logic             r_sum_vld;
  logic [DW-1:0]    r_sum_out;
  logic             r_exp_err;
  logic [SW-1:0]    r_al_sum;
  logic             r_al_vld;
  logic [AW_L-1:0]  r_acc;

  logic             w_beat;
  logic [7:0]       w_exp [LANES];
  logic [MW_L-1:0]  w_man [LANES];
  logic [8:0]       w_d   [LANES];
  logic [MW_L:0]    w_al  [LANES];
  logic [SW-1:0]    w_line_sum;
  logic             w_lane_err;

  logic [AW_L-1:0]  w_lod_in;
  logic [PW-1:0]    w_p;
  logic             w_zero;
  logic [PW-1:0]    w_amt;
  logic [AW_L-1:0]  w_shift;
  logic [MW_L-1:0]  w_mant;
  logic [MW_L-1:0]  w_mant_f;
  logic signed [10:0] w_e;
  logic signed [10:0] w_e_f;
  logic [DW-1:0]    w_sum;
  logic             w_unused;

  assign w_beat    = in_vld && r_in_ready;
  assign in_ready  = r_in_ready;
  assign sum_vld   = r_sum_vld;
  assign sum_out   = r_sum_out;
  assign exp_err   = r_exp_err;
  assign dbg_state = r_state;

  // Align every lane of the incoming line to emax and add the four lanes.
  always_comb begin
    w_line_sum = '0;
    w_lane_err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w_exp[k] = lane_exp(in_data[k*DW +: DW]);
      w_man[k] = lane_man(in_data[k*DW +: DW]);
      w_d[k]   = {1'b0, r_emax} - {1'b0, w_exp[k]};
      w_al[k]  = '0;
      if (w_exp[k] == 8'd0) begin
        w_al[k] = '0;
      end else if (w_exp[k] > r_emax) begin
        w_lane_err = 1'b1;
      end else if (w_d[k] <= 9'(MW_L)) begin
        w_al[k] = {1'b1, w_man[k]} >> w_d[k];
      end
      w_line_sum = w_line_sum + SW'(w_al[k]);
    end
  end

  // Leading-one search only sees the accumulator while normalizing.
  assign w_lod_in = (r_state == S_NORM) ? r_acc : '0;

  lead_one_det #(.W(AW_L), .PW(PW)) u_lod (
    .i_vec  (w_lod_in),
    .o_pos  (w_p),
    .o_zero (w_zero)
  );

  // Normalize the accumulator: left-justify the leading one, take the MW bits below it.
  assign w_amt    = PW'(AW_L - 1) - w_p;
  assign w_shift  = r_acc << w_amt;
  assign w_mant   = w_shift[AW_L-2 -: MW_L];
  assign w_e      = $signed({3'b000, r_emax}) + $signed({{(11-PW){1'b0}}, w_p})
                    - $signed(11'(MW_L));
  assign w_unused = ^{w_shift[AW_L-1], w_shift[AW_L-MW_L-2:0]};

`ifdef NODE_SUM_ROUND_EN
  logic [MW_L:0] w_mant_r;
  // Half-up rounding on the first discarded bit; a carry bumps the exponent.
  always_comb begin
    w_mant_r = {1'b0, w_mant} + (MW_L+1)'(w_shift[AW_L-MW_L-2]);
    if (w_mant_r[MW_L]) begin
      w_e_f    = w_e + 11'sd1;
      w_mant_f = '0;
    end else begin
      w_e_f    = w_e;
      w_mant_f = w_mant_r[MW_L-1:0];
    end
  end
`else
  assign w_e_f    = w_e;
  assign w_mant_f = w_mant;
`endif

  // Flush to zero on underflow, saturate on overflow.
  always_comb begin
    if (w_zero || (w_e_f <= 11'sd0)) begin
      w_sum = '0;
    end else if (w_e_f >= 11'sd255) begin
      w_sum = {8'hFF, {MW_L{1'b1}}};
    end else begin
      w_sum = {w_e_f[7:0], w_mant_f};
    end
  end

  // Node-level FSM: capture node header, count lines, drain pipeline, present sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_emax     <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_sum_vld  <= 1'b0;
      r_sum_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (max_exponent_vld) begin
            r_emax     <= max_exponent;
            r_last     <= num_of_line_per_node_minusone;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 11'd1;
            if (r_cnt == r_last) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: r_state <= S_NORM;
        S_NORM: begin
          r_sum_out <= w_sum;
          r_sum_vld <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (sum_ready) begin
            r_sum_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Align stage register and sticky exponent error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_al_sum  <= '0;
      r_al_vld  <= 1'b0;
      r_exp_err <= 1'b0;
    end else begin
      r_al_vld <= w_beat;
      if (w_beat) r_al_sum <= w_line_sum;
      if (w_beat && w_lane_err) r_exp_err <= 1'b1;
    end
  end

  // Wide accumulator: cleared at node start, adds one aligned line per beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if ((r_state == S_IDLE) && max_exponent_vld) begin
      r_acc <= '0;
    end else if (r_al_vld) begin
      r_acc <= r_acc + AW_L'(r_al_sum);
    end
  end

endmodule

// File: tb/tb_node_sum_accum.sv
// Directed bench for node_sum_accum (DW = 16).
module tb_node_sum_accum;
  import prob_circ_pkg::*;

  logic            clk;
  logic            rst;
  logic [63:0]     in_data;
  logic            in_vld;
  logic            in_ready;
  logic [7:0]      max_exponent;
  logic            max_exponent_vld;
  logic [10:0]     num_of_line_per_node_minusone;
  logic [15:0]     sum_out;
  logic            sum_vld;
  logic            sum_ready;
  logic            exp_err;
  node_sum_state_t dbg_state;

  int n_vec;
  int n_err;
  logic [15:0] exp_q[$];

  node_sum_accum #(.DW(16), .LANES(4)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .in_data                       (in_data),
    .in_vld                        (in_vld),
    .in_ready                      (in_ready),
    .max_exponent                  (max_exponent),
    .max_exponent_vld              (max_exponent_vld),
    .num_of_line_per_node_minusone (num_of_line_per_node_minusone),
    .sum_out                       (sum_out),
    .sum_vld                       (sum_vld),
    .sum_ready                     (sum_ready),
    .exp_err                       (exp_err),
    .dbg_state                     (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic start_node(input logic [7:0] emax, input logic [10:0] last);
    @(negedge clk);
    max_exponent                  = emax;
    num_of_line_per_node_minusone = last;
    max_exponent_vld              = 1'b1;
    @(negedge clk);
    max_exponent_vld              = 1'b0;
  endtask

  // Present one line, wait for acceptance; returns at the negedge after the accepting edge.
  task automatic send_line(input logic [63:0] data, input bit keep);
    int guard;
    guard   = 0;
    in_data = data;
    in_vld  = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    if (!keep) in_vld = 1'b0;
  endtask

  // Called at the negedge after the last accepted beat; lat counts negedges since that edge.
  task automatic wait_sum(output int lat);
    lat = 1;
    while (!sum_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (sum_vld !== 1'b1) begin
      n_err++;
      $display("FAIL sum_timeout: sum_vld=%b required 1", sum_vld);
    end
  endtask

  // Scoreboard check of the presented sum, then the handshake.
  task automatic pop_sum(input string name);
    logic [15:0] exp_v;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (sum_out !== exp_v) begin
      n_err++;
      $display("FAIL %s: sum_out=%h required %h", name, sum_out, exp_v);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    n_vec++;
    if (sum_vld !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL %s_release: sum_vld=%b state=%0d required 0/%0d",
               name, sum_vld, dbg_state, S_IDLE);
    end
  endtask

  task automatic run_node(input logic [7:0] emax, input logic [63:0] line,
                          input logic [15:0] exp_v, input string name);
    int lat;
    exp_q.push_back(exp_v);
    start_node(emax, 11'd0);
    send_line(line, 1'b0);
    wait_sum(lat);
    pop_sum(name);
  endtask

  task automatic check_err(input logic req, input string name);
    n_vec++;
    if (exp_err !== req) begin
      n_err++;
      $display("FAIL %s: exp_err=%b required %b", name, exp_err, req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++;
    if (in_ready !== 1'b0 || sum_vld !== 1'b0 || sum_out !== 16'h0000 ||
        exp_err !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b vld=%b out=%h err=%b st=%0d required 0 0 0000 0 0",
               in_ready, sum_vld, sum_out, exp_err, dbg_state);
    end
  endtask

  // 4 x 1.0 = 4.0 with the three-cycle latency.
  task automatic test_one_line();
    int lat;
    exp_q.push_back(16'h8100);
    start_node(8'd127, 11'd0);
    send_line({4{16'h7F00}}, 1'b0);
    wait_sum(lat);
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL one_line_latency: latency=%0d required 3", lat);
    end
    pop_sum("one_line");
  endtask

  // Two lines of 4 x 1.0 with a bubble between them: 8.0.
  task automatic test_multi_line();
    int lat;
    exp_q.push_back(16'h8200);
    start_node(8'd127, 11'd1);
    send_line({4{16'h7F00}}, 1'b0);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL multi_line_bubble: in_ready=%b required 1", in_ready);
    end
    send_line({4{16'h7F00}}, 1'b0);
    wait_sum(lat);
    pop_sum("multi_line");
  endtask

  // 1.0 + 0.5 + 0.5 + 0 = 2.0.
  task automatic test_alignment();
    run_node(8'd127, {16'h7F00, 16'h7E00, 16'h7E00, 16'h0000}, 16'h8000, "alignment");
    check_err(1'b0, "alignment_err");
  endtask

  // d = MW keeps only the hidden bit (1/256); d = MW+1 contributes nothing.
  task automatic test_shift_limits();
    run_node(8'd127, {16'h7F00, 16'h7700, 16'h7600, 16'h0000}, 16'h7F01, "shift_limits");
  endtask

  // All-zero lanes give a zero sum; large sums saturate.
  task automatic test_zero_and_saturation();
    run_node(8'd127, 64'h0, 16'h0000, "zero_node");
    run_node(8'd255, {4{16'hFF00}}, 16'hFFFF, "saturation");
  endtask

  // Back-to-back 2048-line node: 8192 x 1.0 = 2^13 -> exp 140.
  task automatic test_back_to_back();
    int lat;
    exp_q.push_back(16'h8C00);
    start_node(8'd127, 11'd2047);
    for (int i = 0; i < 2047; i++) send_line({4{16'h7F00}}, 1'b1);
    send_line({4{16'h7F00}}, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || dbg_state !== S_DRAIN) begin
      n_err++;
      $display("FAIL full_node_end: in_ready=%b state=%0d required 0/%0d",
               in_ready, dbg_state, S_DRAIN);
    end
    wait_sum(lat);
    pop_sum("full_node");
    run_node(8'd127, {4{16'h7F00}}, 16'h8100, "next_node");
  endtask

  // Lane above emax is dropped and the error sticks.
  task automatic test_exp_err();
    run_node(8'd127, {16'h8000, 16'h7F00, 16'h0000, 16'h0000}, 16'h7F00, "exp_err_sum");
    check_err(1'b1, "exp_err_set");
    run_node(8'd127, {4{16'h7F00}}, 16'h8100, "exp_err_after");
    check_err(1'b1, "exp_err_sticky");
  endtask

  task automatic test_backpressure_reset();
    int lat;
    start_node(8'd127, 11'd0);
    send_line({4{16'h7F00}}, 1'b0);
    wait_sum(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (sum_vld !== 1'b1 || sum_out !== 16'h8100 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold: vld=%b out=%h rdy=%b required 1 8100 0",
                 sum_vld, sum_out, in_ready);
      end
    end
    // Header offered in the same cycle as the pop must be ignored.
    max_exponent                  = 8'd100;
    num_of_line_per_node_minusone = 11'd0;
    max_exponent_vld              = 1'b1;
    sum_ready                     = 1'b1;
    @(negedge clk);
    max_exponent_vld = 1'b0;
    sum_ready        = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dbg_state !== S_IDLE || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pop_header_ignored: state=%0d rdy=%b required %0d/0",
               dbg_state, in_ready, S_IDLE);
    end
    check_err(1'b1, "err_before_reset");
    // Reset in the middle of a node.
    start_node(8'd127, 11'd3);
    send_line({4{16'h7F00}}, 1'b0);
    n_vec++;
    if (dbg_state !== S_ACC) begin
      n_err++;
      $display("FAIL pre_reset_state: state=%0d required %0d", dbg_state, S_ACC);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || sum_vld !== 1'b0 || sum_out !== 16'h0000 ||
        exp_err !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL mid_node_reset: rdy=%b vld=%b out=%h err=%b st=%0d required 0 0 0000 0 0",
               in_ready, sum_vld, sum_out, exp_err, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    run_node(8'd127, {4{16'h7F00}}, 16'h8100, "after_reset");
  endtask

  // 4 x 0x101 = 0x404: exact. 0x1FF + 0x40 = 0x23F: mantissa bits 0x1F, first dropped bit 1.
  task automatic test_rounding();
    run_node(8'd127, {4{16'h7F01}}, 16'h8101, "round_exact");
`ifdef NODE_SUM_ROUND_EN
    run_node(8'd127, {16'h7FFF, 16'h7D00, 16'h0000, 16'h0000}, 16'h8020, "round_dropped");
`else
    run_node(8'd127, {16'h7FFF, 16'h7D00, 16'h0000, 16'h0000}, 16'h801F, "trunc_dropped");
`endif
  endtask

  initial begin
    n_vec                         = 0;
    n_err                         = 0;
    rst                           = 1'b0;
    in_data                       = '0;
    in_vld                        = 1'b0;
    max_exponent                  = '0;
    max_exponent_vld              = 1'b0;
    num_of_line_per_node_minusone = '0;
    sum_ready                     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_one_line();
    test_multi_line();
    test_alignment();
    test_shift_limits();
    test_zero_and_saturation();
    test_back_to_back();
    test_exp_err();
    test_backpressure_reset();
    test_rounding();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: entries=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
